// File: rtl/sig_pkg.sv
// Shared constants for the sig_edge_filter block: edge_mode encodings and
// the minimum synchroniser depth.
package sig_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sig_edge_chan.sv
// One channel of the edge filter: synchroniser chain, glitch filter with a
// shared threshold, registered rising/falling pulses, mode-selected event
// pulse and a software-clearable sticky flag.
module sig_edge_chan
  import sig_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CNT_W  = 4,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig,
  input  logic [FILT_CNT_W-1:0] filt_len,
  input  logic [1:0]            mode,
  input  logic                  clr,
  output logic                  level,
  output logic                  rising,
  output logic                  falling,
  output logic                  evt_pulse,
  output logic                  sticky
);

  // Never build a chain shallower than two flops, whatever the parameter says.
  localparam int SYNC_W = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam logic [FILT_CNT_W-1:0] CNT_MAX = {FILT_CNT_W{1'b1}};

  logic [SYNC_W-1:0]     sync_q;
  logic                  sync_out;
  logic [FILT_CNT_W-1:0] cnt;
  logic                  differ;
  logic                  update;

  assign sync_out = sync_q[SYNC_W-1];
  assign differ   = sync_out ^ level;
  // >= rather than == so a threshold lowered mid-count fires on the next cycle.
  assign update   = differ && (cnt >= filt_len);

  // Metastability chain: shift the raw input towards sync_out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {SYNC_W{RST_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_W-2:0], sig};
    end
  end

  // Glitch filter: accept a new level once it has differed for filt_len+1 cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      level <= RST_BIT;
    end else if (!differ) begin
      cnt <= '0;
    end else if (update) begin
      level <= sync_out;
      cnt   <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Edge pulses, aligned with the cycle the new level first appears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rising  <= 1'b0;
      falling <= 1'b0;
    end else begin
      rising  <= update & sync_out;
      falling <= update & ~sync_out;
    end
  end

  // Event select from the registered edges and the live mode setting.
  always_comb begin
    evt_pulse = 1'b0;
    case (mode)
      EDGE_OFF:  evt_pulse = 1'b0;
      EDGE_RISE: evt_pulse = rising;
      EDGE_FALL: evt_pulse = falling;
      EDGE_BOTH: evt_pulse = rising | falling;
      default:   evt_pulse = 1'b0;
    endcase
  end

  // Sticky flag: a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky <= 1'b0;
    end else if (evt_pulse) begin
      sticky <= 1'b1;
    end else if (clr) begin
      sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/sig_edge_filter.sv
// Multi-channel synchronised, glitch-filtered edge detector with per-channel
// event selection, sticky flags and a global any-event indication.
module sig_edge_filter
  import sig_pkg::*;
#(
  parameter int                 CH_NUM      = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter int                 FILT_CNT_W  = 4,
  parameter logic [CH_NUM-1:0]  RST_VAL     = {CH_NUM{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CH_NUM-1:0]     sig,
  input  logic [FILT_CNT_W-1:0] filt_len,
  input  logic [2*CH_NUM-1:0]   edge_mode,
  input  logic [CH_NUM-1:0]     evt_clr,
  output logic [CH_NUM-1:0]     sig_level,
  output logic [CH_NUM-1:0]     sig_rising,
  output logic [CH_NUM-1:0]     sig_falling,
  output logic [CH_NUM-1:0]     evt_pulse,
  output logic [CH_NUM-1:0]     evt_sticky,
  output logic                  evt_any
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    sig_edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CNT_W  (FILT_CNT_W),
      .RST_BIT     (RST_VAL[i])
    ) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .sig       (sig[i]),
      .filt_len  (filt_len),
      .mode      (edge_mode[2*i +: 2]),
      .clr       (evt_clr[i]),
      .level     (sig_level[i]),
      .rising    (sig_rising[i]),
      .falling   (sig_falling[i]),
      .evt_pulse (evt_pulse[i]),
      .sticky    (evt_sticky[i])
    );
  end

  // Any latched event across all channels.
  always_comb begin
    evt_any = |evt_sticky;
  end

endmodule

// File: tb/tb_sig_edge_filter.sv
// Directed + randomized bench for sig_edge_filter with a behavioural model.
module tb_sig_edge_filter;

  localparam int CH = 8;
  localparam int S  = 2;
  localparam int FW = 4;
  localparam logic [CH-1:0] RV = 8'h0F;

  logic            clk = 1'b0;
  logic            rstn;
  logic [CH-1:0]   sig;
  logic [FW-1:0]   filt_len;
  logic [2*CH-1:0] edge_mode;
  logic [CH-1:0]   evt_clr;
  logic [CH-1:0]   sig_level, sig_rising, sig_falling, evt_pulse, evt_sticky;
  logic            evt_any;

  sig_edge_filter #(.CH_NUM(CH), .SYNC_STAGES(S), .FILT_CNT_W(FW), .RST_VAL(RV)) dut (
    .clk(clk), .rstn(rstn), .sig(sig), .filt_len(filt_len), .edge_mode(edge_mode),
    .evt_clr(evt_clr), .sig_level(sig_level), .sig_rising(sig_rising),
    .sig_falling(sig_falling), .evt_pulse(evt_pulse), .evt_sticky(evt_sticky),
    .evt_any(evt_any)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state: sample history, differing-streak lengths, outputs.
  logic [CH-1:0] mhist [S];
  int            mrun  [CH];
  logic [CH-1:0] mlev, mrise, mfall, mstk;
  logic [CH-1:0] acc_pulse;
  int            pcnt  [CH];

  function automatic logic [CH-1:0] evt_of(logic [CH-1:0] r, logic [CH-1:0] f, logic [2*CH-1:0] m);
    logic [CH-1:0] e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      case (m[2*i +: 2])
        2'b01:   e[i] = r[i];
        2'b10:   e[i] = f[i];
        2'b11:   e[i] = r[i] | f[i];
        default: e[i] = 1'b0;
      endcase
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) mhist[k] = RV;
    for (int i = 0; i < CH; i++) mrun[i] = 0;
    mlev = RV; mrise = '0; mfall = '0; mstk = '0;
  endtask

  task automatic model_step();
    logic [CH-1:0] so, oevt, nr, nf;
    if (!rstn) begin
      model_reset();
      return;
    end
    oevt = evt_of(mrise, mfall, edge_mode);
    so = mhist[S-1];
    nr = '0; nf = '0;
    for (int i = 0; i < CH; i++) begin
      if (so[i] != mlev[i]) begin
        if (mrun[i] >= int'(filt_len)) begin
          mlev[i] = so[i]; nr[i] = so[i]; nf[i] = ~so[i]; mrun[i] = 0;
        end else begin
          mrun[i] = mrun[i] + 1;
        end
      end else begin
        mrun[i] = 0;
      end
    end
    mrise = nr; mfall = nf;
    mstk = oevt | (mstk & ~evt_clr);
    for (int k = S-1; k > 0; k--) mhist[k] = mhist[k-1];
    mhist[0] = sig;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [CH-1:0] mevt;
    mevt = evt_of(mrise, mfall, edge_mode);
    chk("level",   32'(sig_level),   32'(mlev));
    chk("rising",  32'(sig_rising),  32'(mrise));
    chk("falling", 32'(sig_falling), 32'(mfall));
    chk("evt",     32'(evt_pulse),   32'(mevt));
    chk("sticky",  32'(evt_sticky),  32'(mstk));
    chk("any",     32'(evt_any),     32'(|mstk));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
    acc_pulse = acc_pulse | sig_rising | sig_falling | evt_pulse;
    for (int i = 0; i < CH; i++) if (evt_pulse[i]) pcnt[i]++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rstn = 1'b0; sig = RV; filt_len = '0; edge_mode = '0; evt_clr = '0;
    acc_pulse = '0;
    for (int i = 0; i < CH; i++) pcnt[i] = 0;
    model_reset();

    // Reset with inputs already at the reset level: nothing should ever pulse.
    ticks(3);
    rstn = 1'b1;
    acc_pulse = '0;
    ticks(20);
    chk("rst_level", 32'(sig_level), 32'h0F);
    chk("rst_nopulse", 32'(acc_pulse), 32'h0);

    // Latency with filt_len=0: ch0 falls then rises, 3 edges each.
    sig[0] = 1'b0;
    ticks(2);
    chk("lat_fall_early", 32'(sig_level[0]), 32'h1);
    tick();
    chk("lat_fall_lvl", 32'(sig_level[0]), 32'h0);
    chk("lat_fall_pulse", 32'(sig_falling[0]), 32'h1);
    tick();
    chk("lat_fall_width", 32'(sig_falling[0]), 32'h0);
    ticks(2);
    sig[0] = 1'b1;
    ticks(2);
    chk("lat_rise_early", 32'(sig_rising[0]), 32'h0);
    tick();
    chk("lat_rise_pulse", 32'(sig_rising[0]), 32'h1);
    chk("lat_rise_lvl", 32'(sig_level[0]), 32'h1);
    tick();
    chk("lat_rise_width", 32'(sig_rising[0]), 32'h0);

    // Glitch rejection with filt_len=3 on ch1.
    filt_len = 4'd3;
    sig[1] = 1'b0;
    ticks(10);
    sig[1] = 1'b1;
    ticks(3);
    sig[1] = 1'b0;
    acc_pulse = '0;
    ticks(10);
    chk("glitch_lvl", 32'(sig_level[1]), 32'h0);
    chk("glitch_nopulse", 32'(acc_pulse[1]), 32'h0);
    sig[1] = 1'b1;
    ticks(5);
    chk("filt_rise_early", 32'(sig_rising[1]), 32'h0);
    tick();
    chk("filt_rise_at6", 32'(sig_rising[1]), 32'h1);

    // Mode select on ch2..5.
    filt_len = 4'd0;
    sig[5:2] = 4'b0000;
    ticks(8);
    edge_mode = 16'h0390;
    for (int i = 0; i < CH; i++) pcnt[i] = 0;
    sig[5:2] = 4'b1111;
    ticks(6);
    sig[5:2] = 4'b0000;
    ticks(6);
    chk("mode_rise_cnt", 32'(pcnt[2]), 32'd1);
    chk("mode_fall_cnt", 32'(pcnt[3]), 32'd1);
    chk("mode_both_cnt", 32'(pcnt[4]), 32'd2);
    chk("mode_off_cnt",  32'(pcnt[5]), 32'd0);

    // Sticky set/clear collision on ch2 (RISE), with every clear held high.
    evt_clr = '1;
    sig[2] = 1'b1;
    ticks(3);
    chk("coll_pulse", 32'(evt_pulse[2]), 32'h1);
    tick();
    chk("coll_set_wins", 32'(evt_sticky[2]), 32'h1);
    chk("coll_any", 32'(evt_any), 32'h1);
    tick();
    chk("clr_alone", 32'(evt_sticky[2]), 32'h0);
    chk("clr_any", 32'(evt_any), 32'h0);
    evt_clr = '0;

    // Threshold shrink mid-count on ch6.
    filt_len = 4'd15;
    sig[6] = 1'b1;
    ticks(10);
    chk("shrink_before", 32'(sig_level[6]), 32'h0);
    filt_len = 4'd2;
    tick();
    chk("shrink_lvl", 32'(sig_level[6]), 32'h1);
    chk("shrink_rise", 32'(sig_rising[6]), 32'h1);

    // Reset mid-count on ch7, then release with inputs at the reset level.
    filt_len = 4'd15;
    sig[7] = 1'b1;
    ticks(6);
    rstn = 1'b0;
    model_reset();
    sig = RV;
    #1;
    check_outputs();
    chk("midrst_lvl", 32'(sig_level), 32'h0F);
    ticks(2);
    rstn = 1'b1;
    acc_pulse = '0;
    ticks(20);
    chk("midrst_nopulse", 32'(acc_pulse), 32'h0);
    chk("midrst_lvl_after", 32'(sig_level), 32'h0F);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) filt_len = FW'($urandom_range(0, 3));
      if (c % 37 == 0) edge_mode = 16'($urandom);
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) sig[i] = ~sig[i];
        evt_clr[i] = ($urandom_range(0, 9) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
